// File: rtl/trig_pkg.sv
// Shared types and helpers for the trigger sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package trig_pkg;

    // Sequencer FSM states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Widest counter the helpers handle; callers zero-extend into this width.
    localparam int TRIG_MAX_W = 64;

    // A programmed period of 0 behaves like a period of 1.
    function automatic logic [TRIG_MAX_W-1:0] clamp_period(input logic [TRIG_MAX_W-1:0] p);
        return (p == '0) ? TRIG_MAX_W'(1) : p;
    endfunction

    // True while cnt lies in [delay, min(delay+width, period)).
    // The end point is formed one bit wider so delay+width never wraps.
    function automatic logic window_hit(
        input logic [TRIG_MAX_W-1:0] cnt,
        input logic [TRIG_MAX_W-1:0] delay,
        input logic [TRIG_MAX_W-1:0] width,
        input logic [TRIG_MAX_W-1:0] period
    );
        logic [TRIG_MAX_W:0] w_end;
        logic [TRIG_MAX_W:0] w_lim;
        w_end = {1'b0, delay} + {1'b0, width};
        w_lim = (w_end < {1'b0, period}) ? w_end : {1'b0, period};
        return (cnt >= delay) && ({1'b0, cnt} < w_lim);
    endfunction

endpackage

// File: rtl/trig_channel.sv
// One trigger lane: shadow delay/width/enable plus the registered output.
// Latency: one clock from the shared phase counter to o_trig.
// Backpressure: none; evaluates every cycle.
module trig_channel
    import trig_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_cfg_delay,
    input  logic [CNT_W-1:0] i_cfg_width,
    input  logic             i_cfg_en,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_period,
    input  logic             i_reload,
    input  logic             i_run,
    output logic             o_trig
);

    logic [CNT_W-1:0] r_delay;
    logic [CNT_W-1:0] r_width;
    logic             r_en;
    logic             r_trig;
    logic             w_hit;

    assign w_hit = window_hit(TRIG_MAX_W'(i_cnt), TRIG_MAX_W'(r_delay),
                              TRIG_MAX_W'(r_width), TRIG_MAX_W'(i_period));

    // Shadow config reloads on launch/wrap; output registers the window test.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_delay <= '0;
            r_width <= '0;
            r_en    <= 1'b0;
            r_trig  <= 1'b0;
        end else begin
            if (i_reload) begin
                r_delay <= i_cfg_delay;
                r_width <= i_cfg_width;
                r_en    <= i_cfg_en;
            end
            r_trig <= i_run && r_en && w_hit;
        end
    end

    assign o_trig = r_trig;

endmodule

// File: rtl/axis_trigger_seq.sv
// Multi-channel trigger sequencer: shared phase counter, per-channel windows, burst/continuous.
// Latency: outputs trail the phase counter by one clock; start to first period_start is two edges.
// Backpressure: none; one count per cycle, stop aborts at the next edge.
module axis_trigger_seq
    import trig_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [CNT_W-1:0]        cfg_period,
    input  logic [NUM_CH*CNT_W-1:0] cfg_delay,
    input  logic [NUM_CH*CNT_W-1:0] cfg_width,
    input  logic [NUM_CH-1:0]       cfg_ch_en,
    input  logic                    cfg_burst,
    input  logic [BURST_W-1:0]      cfg_burst_len,
    input  logic                    start,
    input  logic                    stop,
    output logic [NUM_CH-1:0]       trigger_out,
    output logic                    period_start,
    output logic                    busy,
    output logic                    done
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_period;
    logic               r_burst;
    logic [BURST_W-1:0] r_left;
    logic               r_ps;
    logic               r_busy;
    logic               r_done;

    logic [CNT_W-1:0]   w_p;
    logic               w_run;
    logic               w_wrap;
    logic               w_launch;
    logic               w_reload;
    logic [BURST_W-1:0] w_left_init;
    logic [NUM_CH-1:0]  w_trig;

    assign w_p         = CNT_W'(clamp_period(TRIG_MAX_W'(r_period)));
    assign w_run       = (r_state == RUN);
    assign w_wrap      = w_run && (r_cnt == (w_p - CNT_W'(1)));
    assign w_launch    = (r_state == IDLE) && start && !stop;
    // Channel shadows follow the period shadow: loaded at launch and at every wrap.
    assign w_reload    = w_launch || w_wrap;
    // A burst length of 0 runs a single period, same as 1.
    assign w_left_init = (cfg_burst_len == '0) ? '0 : (cfg_burst_len - BURST_W'(1));

    // Sequencer FSM: phase counter, period shadow, burst accounting and status flops.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_burst  <= 1'b0;
            r_left   <= '0;
            r_ps     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt  <= '0;
                    r_ps   <= 1'b0;
                    r_done <= 1'b0;
                    if (w_launch) begin
                        r_period <= cfg_period;
                        r_burst  <= cfg_burst;
                        r_left   <= w_left_init;
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                    end
                end
                RUN: begin
                    // period_start is the registered image of phase 0
                    r_ps   <= (r_cnt == '0);
                    r_done <= 1'b0;
                    if (stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_wrap) begin
                        r_cnt    <= '0;
                        r_period <= cfg_period;
                        if (r_burst) begin
                            if (r_left == '0) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_left <= r_left - BURST_W'(1);
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            trig_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .i_clk       (aclk),
                .i_rst       (areset),
                .i_cfg_delay (cfg_delay[gi*CNT_W +: CNT_W]),
                .i_cfg_width (cfg_width[gi*CNT_W +: CNT_W]),
                .i_cfg_en    (cfg_ch_en[gi]),
                .i_cnt       (r_cnt),
                .i_period    (w_p),
                .i_reload    (w_reload),
                .i_run       (w_run),
                .o_trig      (w_trig[gi])
            );
        end
    endgenerate

    assign trigger_out  = w_trig;
    assign period_start = r_ps;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_axis_trigger_seq.sv
// Directed bench for axis_trigger_seq with hand-computed per-cycle expectations.
// Status word layout used in checks: {done, busy, period_start, trigger_out[3:0]}.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_axis_trigger_seq;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 32;
    localparam int BURST_W = 16;

    logic                    aclk;
    logic                    areset;
    logic [CNT_W-1:0]        cfg_period;
    logic [NUM_CH*CNT_W-1:0] cfg_delay;
    logic [NUM_CH*CNT_W-1:0] cfg_width;
    logic [NUM_CH-1:0]       cfg_ch_en;
    logic                    cfg_burst;
    logic [BURST_W-1:0]      cfg_burst_len;
    logic                    start;
    logic                    stop;
    logic [NUM_CH-1:0]       trigger_out;
    logic                    period_start;
    logic                    busy;
    logic                    done;

    int total;
    int bad;

    axis_trigger_seq #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_period    (cfg_period),
        .cfg_delay     (cfg_delay),
        .cfg_width     (cfg_width),
        .cfg_ch_en     (cfg_ch_en),
        .cfg_burst     (cfg_burst),
        .cfg_burst_len (cfg_burst_len),
        .start         (start),
        .stop          (stop),
        .trigger_out   (trigger_out),
        .period_start  (period_start),
        .busy          (busy),
        .done          (done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] st();
        return 64'({done, busy, period_start, trigger_out});
    endfunction

    task automatic set_ch(input int ch, input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] w);
        cfg_delay[ch*CNT_W +: CNT_W] = d;
        cfg_width[ch*CNT_W +: CNT_W] = w;
    endtask

    // Abort a run and let the output pipeline drain.
    task automatic stop_run();
        start = 1'b0;
        stop  = 1'b1;
        step();
        stop  = 1'b0;
        step();
    endtask

    initial begin
        logic [63:0] exp;
        int ph;
        int hi, rises, dn, done_k, fall_k, ps_cnt;
        logic prev_t, prev_b;

        total = 0;
        bad   = 0;

        // ---- 1: reset with everything nonzero and start held ----
        areset        = 1'b1;
        cfg_period    = 32'd8;
        cfg_delay     = '1;
        cfg_width     = '1;
        cfg_ch_en     = '1;
        cfg_burst     = 1'b1;
        cfg_burst_len = 16'd3;
        start         = 1'b1;
        stop          = 1'b0;
        step();
        chk("reset_a", st(), 64'h0);
        step();
        chk("reset_b", st(), 64'h0);
        areset = 1'b0;
        step();
        // start is sampled on this edge: busy rises, everything else still 0
        chk("post_reset", st(), 64'h20);
        stop_run();
        chk("post_reset_stop", st(), 64'h0);

        // ---- 2: continuous, period 8 ----
        cfg_period = 32'd8;
        cfg_burst  = 1'b0;
        set_ch(0, 0, 1);
        set_ch(1, 3, 2);
        set_ch(2, 0, 8);
        set_ch(3, 0, 8);
        cfg_ch_en = 4'b0011;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("cont_E0", st(), 64'h20);
        for (int k = 1; k <= 24; k++) begin
            step();
            ph  = (k - 1) % 8;
            exp = 64'h20;
            if (ph == 0) begin
                exp[0] = 1'b1;
                exp[4] = 1'b1;
            end
            if (ph == 3 || ph == 4) exp[1] = 1'b1;
            chk($sformatf("cont_k%0d", k), st(), exp);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("cont_stop_busy", 64'({done, busy}), 64'h0);
        step();
        chk("cont_stop_out", st(), 64'h0);

        // ---- 3: burst, period 5, length 3 ----
        cfg_period    = 32'd5;
        cfg_burst     = 1'b1;
        cfg_burst_len = 16'd3;
        set_ch(0, 0, 2);
        cfg_ch_en = 4'b0001;
        start = 1'b1;
        step();
        start = 1'b0;
        hi = 0; rises = 0; dn = 0; done_k = 0; fall_k = 0; ps_cnt = 0;
        prev_t = 1'b0; prev_b = busy;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (trigger_out[0]) hi++;
            if (trigger_out[0] && !prev_t) rises++;
            if (period_start) ps_cnt++;
            if (done) begin
                dn++;
                done_k = k;
            end
            if (prev_b && !busy) fall_k = k;
            prev_t = trigger_out[0];
            prev_b = busy;
        end
        chk("burst3_high_cycles", 64'(hi), 64'd6);
        chk("burst3_pulses", 64'(rises), 64'd3);
        chk("burst3_period_starts", 64'(ps_cnt), 64'd3);
        chk("burst3_done_count", 64'(dn), 64'd1);
        chk("burst3_done_cycle", 64'(done_k), 64'd15);
        chk("burst3_busy_fall", 64'(fall_k), 64'd15);
        chk("burst3_idle", st(), 64'h0);

        // burst length 0 behaves as 1
        cfg_burst_len = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        hi = 0; rises = 0; dn = 0; done_k = 0;
        prev_t = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (trigger_out[0]) hi++;
            if (trigger_out[0] && !prev_t) rises++;
            if (done) begin
                dn++;
                done_k = k;
            end
            prev_t = trigger_out[0];
        end
        chk("burst0_pulses", 64'(rises), 64'd1);
        chk("burst0_high_cycles", 64'(hi), 64'd2);
        chk("burst0_done_count", 64'(dn), 64'd1);
        chk("burst0_done_cycle", 64'(done_k), 64'd5);

        // ---- 4: window boundaries, period 8 ----
        cfg_period = 32'd8;
        cfg_burst  = 1'b0;
        set_ch(0, 6, 5);   // clipped to phases 6..7
        set_ch(1, 0, 0);   // zero width
        set_ch(2, 8, 1);   // delay past the period
        cfg_ch_en = 4'b0111;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            ph  = (k - 1) % 8;
            exp = 64'h20;
            if (ph == 0) exp[4] = 1'b1;
            if (ph == 6 || ph == 7) exp[0] = 1'b1;
            chk($sformatf("bound_k%0d", k), st(), exp);
        end
        stop_run();

        // period 0 and period 1 with width 1: constantly high
        set_ch(0, 0, 1);
        cfg_ch_en = 4'b0001;
        for (int p = 0; p <= 1; p++) begin
            cfg_period = 32'(p);
            start = 1'b1;
            step();
            start = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                step();
                chk($sformatf("period%0d_k%0d", p, k), st(), 64'h31);
            end
            stop_run();
            chk($sformatf("period%0d_stopped", p), st(), 64'h0);
        end

        // ---- 5: runtime reload of period and delay ----
        cfg_period = 32'd8;
        set_ch(0, 0, 1);
        set_ch(1, 2, 1);
        cfg_ch_en = 4'b0011;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp = 64'h20;
            if (k <= 8) begin
                ph = k - 1;
                if (ph == 2) exp[1] = 1'b1;
            end else begin
                ph = (k - 9) % 4;
                if (ph == 1) exp[1] = 1'b1;
            end
            if (ph == 0) begin
                exp[0] = 1'b1;
                exp[4] = 1'b1;
            end
            chk($sformatf("reload_k%0d", k), st(), exp);
            if (k == 2) begin
                cfg_period = 32'd4;
                set_ch(1, 1, 1);
            end
        end
        stop_run();

        // ---- 6a: stop at phase 3 of a continuous run ----
        cfg_period = 32'd8;
        set_ch(0, 0, 8);
        cfg_ch_en = 4'b0001;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_edge", st(), 64'h01);
        step();
        chk("stop_after", st(), 64'h0);
        step();
        chk("stop_stays_idle", st(), 64'h0);

        // ---- 6b: start and stop together in IDLE ----
        start = 1'b1;
        stop  = 1'b1;
        step();
        chk("startstop_a", st(), 64'h0);
        step();
        chk("startstop_b", st(), 64'h0);
        start = 1'b0;
        stop  = 1'b0;

        // ---- 6c: reset in the middle of a burst ----
        cfg_period    = 32'd5;
        cfg_burst     = 1'b1;
        cfg_burst_len = 16'd3;
        set_ch(0, 0, 5);
        cfg_ch_en = 4'b0001;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) step();
        chk("midburst_running", st(), 64'h21);
        areset = 1'b1;
        step();
        chk("midburst_reset", st(), 64'h0);
        areset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("midburst_after_k%0d", k), st(), 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
